// File: rtl/fact_accel_if.sv
// Bus-side register port of the factorial accelerator: write enable,
// word select, write data and the combinational read-back path.
interface fact_accel_if #(
  parameter int WIDTH = 32
);
  logic             we;
  logic [1:0]       a;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rd;

  modport master (output we, output a, output wd, input rd);
  modport slave  (input we, input a, input wd, output rd);
endinterface

// File: rtl/fact_accel.sv
// Memory-mapped iterative factorial accelerator, one multiply per cycle.
// Optional FACT_IRQ_EN adds a one-cycle completion irq and sticky STATUS bit 2.
module fact_accel #(
  parameter int WIDTH = 32,
  parameter int NMAX  = 12
) (
  input  logic         clk,
  input  logic         rst,
  fact_accel_if.slave  bus
`ifdef FACT_IRQ_EN
  ,
  output logic         irq
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, MULT, DONE} state_t;

  localparam logic [3:0] NMAX_N = 4'(NMAX);

  state_t           state_reg, state_next;
  logic [3:0]       n_reg, n_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [WIDTH-1:0] product_reg, product_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;
  logic             busy;
  logic             go_write;
  logic             n_write;
  logic             irq_flag_bit;
  logic             unused_wd;

  assign unused_wd = ^bus.wd[WIDTH-1:4];
  assign busy      = (state_reg == LOAD) || (state_reg == MULT);
  assign go_write  = bus.we && (bus.a == 2'd1) && bus.wd[0];
  assign n_write   = bus.we && (bus.a == 2'd0);

`ifdef FACT_IRQ_EN
  logic irq_reg, irq_next;
  logic irq_flag_reg, irq_flag_next;
  assign irq          = irq_reg;
  assign irq_flag_bit = irq_flag_reg;
`else
  assign irq_flag_bit = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    n_next       = n_reg;
    cnt_next     = cnt_reg;
    product_next = product_reg;
    done_next    = done_reg;
    err_next     = err_reg;
`ifdef FACT_IRQ_EN
    irq_flag_next = irq_flag_reg;
`endif
    case (state_reg)
      IDLE, DONE: begin
        if (n_write) begin
          n_next = bus.wd[3:0];
        end
        if (go_write) begin
          done_next  = 1'b0;
          err_next   = 1'b0;
          state_next = LOAD;
`ifdef FACT_IRQ_EN
          irq_flag_next = 1'b0;
`endif
        end
      end
      LOAD: begin
        product_next = {{(WIDTH-1){1'b0}}, 1'b1};
        cnt_next     = n_reg;
        if (n_reg > NMAX_N) begin
          err_next   = 1'b1;
          done_next  = 1'b1;
          state_next = DONE;
        end else begin
          state_next = MULT;
        end
      end
      MULT: begin
        // Counts down from n so the final product needs no extra fix-up cycle.
        if (cnt_reg > 4'd1) begin
          product_next = product_reg * WIDTH'(cnt_reg);
          cnt_next     = cnt_reg - 4'd1;
        end else begin
          done_next  = 1'b1;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
`ifdef FACT_IRQ_EN
    irq_next = (state_next == DONE) && (state_reg != DONE);
    if (irq_next) begin
      irq_flag_next = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      n_reg       <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
`ifdef FACT_IRQ_EN
      irq_reg      <= 1'b0;
      irq_flag_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      n_reg       <= n_next;
      cnt_reg     <= cnt_next;
      product_reg <= product_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
`ifdef FACT_IRQ_EN
      irq_reg      <= irq_next;
      irq_flag_reg <= irq_flag_next;
`endif
    end
  end

  always_comb begin
    bus.rd = '0;
    case (bus.a)
      2'd0:    bus.rd = WIDTH'(n_reg);
      2'd1:    bus.rd = WIDTH'(busy);
      2'd2:    bus.rd = WIDTH'({irq_flag_bit, err_reg, done_reg});
      default: bus.rd = product_reg;
    endcase
  end

endmodule

// File: tb/tb_fact_accel.sv
// Directed self-checking bench for fact_accel; irq checks are enabled
// when FACT_IRQ_EN is defined for both bench and design.
module tb_fact_accel;

  logic clk;
  logic rst;
  int   vec_cnt;
  int   err_cnt;

  fact_accel_if #(.WIDTH(32)) bus ();

`ifdef FACT_IRQ_EN
  logic irq;
  fact_accel #(.WIDTH(32), .NMAX(12)) dut (.clk(clk), .rst(rst), .bus(bus), .irq(irq));
`else
  fact_accel #(.WIDTH(32), .NMAX(12)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.we = 1'b1;
    bus.a  = addr;
    bus.wd = data;
    @(negedge clk);
    bus.we = 1'b0;
    bus.wd = '0;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    bus.a = addr;
    #1;
    data = bus.rd;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", name, got);
    end
  endtask

  // Issues GO and returns the edge number (relative to the GO-write edge) at which done rose.
  task automatic start_and_wait(input logic [3:0] n, output int edge_seen);
    bus_write(2'd0, {28'b0, n});
    bus_write(2'd1, 32'h1);
    bus.a = 2'd2;
    edge_seen = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (bus.rd[0] === 1'b1) begin
        edge_seen = e;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [31:0] v;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_read(2'(i), v);
      if (v !== 32'h0) begin
        err_cnt++;
        $display("FAIL reset_rd a=%0d got=0x%08h exp=0x00000000", i, v);
      end
      vec_cnt++;
      $display("ok   reset_rd a=%0d = 0x%08h", i, v);
    end
  endtask

  task automatic test_regs;
    logic [31:0] v;
    bus_write(2'd0, 32'hFFFF_FFF4);
    bus_read(2'd0, v);
    check("n_mask", v, 32'h4);
    bus_write(2'd1, 32'h2);
    @(posedge clk); #1;
    bus_read(2'd1, v);
    check("go_bit0_zero", v, 32'h0);
    bus_write(2'd3, 32'hDEAD_BEEF);
    bus_read(2'd3, v);
    check("result_ro", v, 32'h0);
  endtask

  task automatic test_fact(input logic [3:0] n, input int exp_edges,
                           input logic [31:0] exp_res, input logic exp_err);
    int          e;
    logic [31:0] v;
    start_and_wait(n, e);
    check($sformatf("latency_n%0d", n), 32'(e), 32'(exp_edges));
    bus_read(2'd2, v);
    check($sformatf("status_n%0d", n), v, {30'b0, exp_err, 1'b1});
    bus_read(2'd3, v);
    check($sformatf("result_n%0d", n), v, exp_res);
  endtask

  task automatic test_busy_writes;
    logic [31:0] v;
    int          e;
    bus_write(2'd0, 32'h5);
    bus_write(2'd1, 32'h1);
    bus_write(2'd0, 32'h2);
    bus_write(2'd1, 32'h1);
    bus.a = 2'd2;
    e = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.rd[0] === 1'b1) begin
        e = i;
        break;
      end
    end
    check("busy_done_seen", 32'(e >= 0), 32'h1);
    bus_read(2'd3, v);
    check("busy_result", v, 32'h78);
    bus_read(2'd0, v);
    check("busy_n_kept", v, 32'h5);
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    bus_write(2'd0, 32'h5);
    bus_write(2'd1, 32'h1);
    @(posedge clk);
    @(posedge clk); #1;
    bus_read(2'd3, v);
    check("partial_product", v, 32'h5);
    bus_read(2'd1, v);
    check("go_busy", v, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus_read(2'd3, v);
    check("rstmid_result", v, 32'h0);
    bus_read(2'd2, v);
    check("rstmid_status", v, 32'h0);
    bus_read(2'd1, v);
    check("rstmid_go", v, 32'h0);
    repeat (8) @(posedge clk);
    #1;
    bus_read(2'd2, v);
    check("rstmid_no_done", v, 32'h0);
  endtask

`ifdef FACT_IRQ_EN
  task automatic test_irq;
    logic [31:0] v;
    int          pulses;
    int          done_edge;
    int          irq_edge;
    bus_write(2'd0, 32'h3);
    bus_write(2'd1, 32'h1);
    bus.a = 2'd2;
    pulses = 0; done_edge = -1; irq_edge = -1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      if (irq === 1'b1) begin
        pulses++;
        irq_edge = e;
      end
      if (bus.rd[0] === 1'b1 && done_edge < 0) done_edge = e;
    end
    check("irq_pulses", 32'(pulses), 32'h1);
    check("irq_edge", 32'(irq_edge), 32'h4);
    check("irq_done_edge", 32'(done_edge), 32'h4);
    bus_read(2'd2, v);
    check("irq_sticky", v, 32'h5);
    bus_write(2'd1, 32'h1);
    bus_read(2'd2, v);
    check("irq_sticky_clr", v, 32'h0);
    repeat (6) @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst     = 1'b1;
    bus.we  = 1'b0;
    bus.a   = 2'd0;
    bus.wd  = '0;
    test_reset();
    test_regs();
    test_fact(4'd4, 5, 32'h0000_0018, 1'b0);
    test_fact(4'd12, 13, 32'h1C8C_FC00, 1'b0);
    test_fact(4'd0, 2, 32'h0000_0001, 1'b0);
    test_fact(4'd1, 2, 32'h0000_0001, 1'b0);
    test_fact(4'd13, 1, 32'h0000_0001, 1'b1);
    test_fact(4'd6, 7, 32'h0000_02D0, 1'b0);
    test_busy_writes();
    test_reset_mid();
`ifdef FACT_IRQ_EN
    test_irq();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
